// File: rtl/alu_regfile_if.sv
// Single-port register bus between a host (master) and alu_regfile (slave).
interface alu_regfile_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  enable;
    logic                  rd_wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output enable,
        output rd_wr,
        output addr,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  enable,
        input  rd_wr,
        input  addr,
        input  wr_data,
        output rd_data
    );
endinterface

// File: rtl/alu_regfile.sv
// Memory-mapped ALU with start/busy/done handshake, restoring divider and sticky flags.
// Optional completion interrupt enabled by defining ALU_REGFILE_IRQ_EN.
module alu_regfile #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    alu_regfile_if.slave            bus,
    output logic [2*DATA_WIDTH-1:0] res_out,
    output logic                    busy,
    output logic                    done,
    output logic                    irq
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    localparam logic [ADDR_WIDTH-1:0] AddrOpa    = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] AddrOpb    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrOper   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] AddrResLo  = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] AddrResHi  = ADDR_WIDTH'(6);

    typedef enum logic [1:0] {StIdle, StExec, StDiv} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;
    logic [2:0]              oper_q, oper_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [2:0]              op_q, op_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [DATA_WIDTH-1:0]   quo_q, quo_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic                    done_q, done_d;
    logic                    div0_q, div0_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    irq_en;

    logic                    wr, rd, start_req;
    logic [2*DATA_WIDTH-1:0] a_ext, b_ext, exec_res;
    logic [DATA_WIDTH:0]     rem_shift, rem_sub;
    logic                    q_bit;
    logic [DATA_WIDTH-1:0]   rem_next, quo_next;

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign res_out     = res_q;
    assign bus.rd_data = rd_data_q;

    assign wr        = bus.enable && !bus.rd_wr;
    assign rd        = bus.enable && bus.rd_wr;
    assign start_req = wr && (bus.addr == AddrCtrl) && bus.wr_data[0];

    assign a_ext = {{DATA_WIDTH{1'b0}}, a_q};
    assign b_ext = {{DATA_WIDTH{1'b0}}, b_q};

    always_comb begin
        exec_res = '0;
        case (op_q)
            3'd1:    exec_res = a_ext + b_ext;
            3'd2:    exec_res = a_ext - b_ext;
            3'd3:    exec_res = a_ext * b_ext;
            default: exec_res = '0;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, b_q};
    assign q_bit     = (rem_shift >= {1'b0, b_q});
    assign rem_next  = q_bit ? rem_sub[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
    assign quo_next  = {quo_q[DATA_WIDTH-2:0], q_bit};

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        oper_d    = oper_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        done_d    = done_q;
        div0_d    = div0_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;

        if (wr) begin
            case (bus.addr)
                AddrOpa:  opa_d  = bus.wr_data;
                AddrOpb:  opb_d  = bus.wr_data;
                AddrOper: oper_d = bus.wr_data[2:0];
                AddrStatus: begin
                    if (bus.wr_data[1]) done_d = 1'b0;
                    if (bus.wr_data[2]) div0_d = 1'b0;
                    if (bus.wr_data[3]) err_d  = 1'b0;
                end
                default: ;
            endcase
        end

        if (rd) begin
            case (bus.addr)
                AddrOpa:    rd_data_d = opa_q;
                AddrOpb:    rd_data_d = opb_q;
                AddrOper:   rd_data_d = DATA_WIDTH'(oper_q);
                AddrCtrl:   rd_data_d = DATA_WIDTH'({irq_en, 1'b0});
                AddrStatus: rd_data_d = DATA_WIDTH'({err_q, div0_q, done_q, busy});
                AddrResLo:  rd_data_d = res_q[DATA_WIDTH-1:0];
                AddrResHi:  rd_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                default:    rd_data_d = '0;
            endcase
        end

        // Completion sets are applied after W1C so a same-edge set wins.
        case (state_q)
            StIdle: begin
                if (start_req) begin
                    a_d     = opa_q;
                    b_d     = opb_q;
                    op_d    = oper_q;
                    rem_d   = '0;
                    quo_d   = opa_q;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    div0_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = (oper_q == 3'd4) ? StDiv : StExec;
                end
            end
            StExec: begin
                done_d  = 1'b1;
                state_d = StIdle;
                if (op_q >= 3'd5) begin
                    err_d = 1'b1;
                end else begin
                    res_d = exec_res;
                end
            end
            StDiv: begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (b_q == '0) begin
                        div0_d = 1'b1;
                        res_d  = {a_q, {DATA_WIDTH{1'b1}}};
                    end else begin
                        res_d = {rem_next, quo_next};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_req && busy) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            opa_q     <= '0;
            opb_q     <= '0;
            oper_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            done_q    <= 1'b0;
            div0_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            oper_q    <= oper_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            done_q    <= done_d;
            div0_q    <= div0_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef ALU_REGFILE_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && (bus.addr == AddrCtrl)) irq_en_d = bus.wr_data[1];
    end

    // irq follows done by one cycle, including when done is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & done_q;
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile (W=8); IRQ checks follow ALU_REGFILE_IRQ_EN.
module tb_alu_regfile;
    logic        clk;
    logic        rst;
    logic [15:0] res_out;
    logic        busy;
    logic        done;
    logic        irq;
    int          total;
    int          bad;

    alu_regfile_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_if ();

    alu_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .res_out (res_out),
        .busy    (busy),
        .done    (done),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus_if.enable  = 1'b1;
        bus_if.rd_wr   = 1'b0;
        bus_if.addr    = a;
        bus_if.wr_data = d;
        @(posedge clk);
        #1;
        bus_if.enable = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus_if.enable = 1'b1;
        bus_if.rd_wr  = 1'b1;
        bus_if.addr   = a;
        @(posedge clk);
        #1;
        bus_if.enable = 1'b0;
        d = bus_if.rd_data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops; cycles already elapsed are passed in.
    task automatic wait_idle(input int start_cnt, output int cycles);
        cycles = start_cnt;
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        bus_if.enable = 1'b0; bus_if.rd_wr = 1'b0; bus_if.addr = '0; bus_if.wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({res_out, busy, done, irq, bus_if.rd_data} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got res=%h busy=%b done=%b irq=%b rd=%h want all 0",
                     res_out, busy, done, irq, bus_if.rd_data);
        end
        rst = 1'b0;
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_status got %h want 00", d); end
        bus_read(3'd0, d);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_opa got %h want 00", d); end
    endtask

    task automatic test_add();
        logic [7:0] d;
        bus_write(3'd0, 8'd200);
        bus_write(3'd1, 8'd100);
        bus_write(3'd2, 8'd1);
        bus_write(3'd3, 8'h01);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL add_busy got busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        total++;
        if (res_out !== 16'h012C || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL add_result got res=%h done=%b busy=%b want 012c 1 0", res_out, done, busy);
        end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL add_status got %h want 02", d); end
        bus_read(3'd2, d);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL oper_readback got %h want 01", d); end
    endtask

    task automatic test_sub_mul();
        logic [7:0] d;
        bus_write(3'd0, 8'd5);
        bus_write(3'd1, 8'd7);
        bus_write(3'd2, 8'd2);
        bus_write(3'd3, 8'h01);
        tick();
        total++;
        if (res_out !== 16'hFFFE || busy !== 1'b0) begin
            bad++; $display("FAIL sub_result got res=%h busy=%b want fffe 0", res_out, busy);
        end
        bus_write(3'd0, 8'd255);
        bus_write(3'd1, 8'd255);
        bus_write(3'd2, 8'd3);
        bus_write(3'd3, 8'h01);
        tick();
        total++;
        if (res_out !== 16'hFE01 || busy !== 1'b0) begin
            bad++; $display("FAIL mul_result got res=%h busy=%b want fe01 0", res_out, busy);
        end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL mul_status got %h want 02", d); end
        bus_read(3'd6, d);
        total++;
        if (d !== 8'hFE) begin bad++; $display("FAIL res_hi_read got %h want fe", d); end
    endtask

    task automatic test_divide();
        int cycles;
        bus_write(3'd0, 8'd200);
        bus_write(3'd1, 8'd7);
        bus_write(3'd2, 8'd4);
        bus_write(3'd3, 8'h01);
        bus_write(3'd0, 8'd3);
        wait_idle(1, cycles);
        total++;
        if (cycles !== 8) begin bad++; $display("FAIL div_latency got %0d want 8", cycles); end
        total++;
        if (res_out !== 16'h041C || done !== 1'b1) begin
            bad++; $display("FAIL div_result got res=%h done=%b want 041c 1", res_out, done);
        end
    endtask

    task automatic test_div0();
        logic [7:0] d;
        int cycles;
        bus_write(3'd0, 8'h55);
        bus_write(3'd1, 8'h00);
        bus_write(3'd3, 8'h01);
        wait_idle(0, cycles);
        total++;
        if (cycles !== 8) begin bad++; $display("FAIL div0_latency got %0d want 8", cycles); end
        total++;
        if (res_out !== 16'h55FF) begin bad++; $display("FAIL div0_result got %h want 55ff", res_out); end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h06) begin bad++; $display("FAIL div0_status got %h want 06", d); end
        bus_write(3'd4, 8'h04);
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL div0_w1c got %h want 02", d); end
    endtask

    task automatic test_hazards();
        logic [7:0] d;
        int cycles;
        bus_write(3'd0, 8'd200);
        bus_write(3'd1, 8'd7);
        bus_write(3'd3, 8'h01);
        bus_write(3'd3, 8'h01);
        wait_idle(1, cycles);
        total++;
        if (cycles !== 8 || res_out !== 16'h041C) begin
            bad++; $display("FAIL busy_start_div got cycles=%0d res=%h want 8 041c", cycles, res_out);
        end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h0A) begin bad++; $display("FAIL busy_start_status got %h want 0a", d); end
        bus_write(3'd2, 8'd6);
        bus_write(3'd3, 8'h01);
        tick();
        total++;
        if (res_out !== 16'h041C || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_op got res=%h done=%b busy=%b want 041c 1 0", res_out, done, busy);
        end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h0A) begin bad++; $display("FAIL bad_op_status got %h want 0a", d); end
    endtask

    task automatic test_completion_edge();
        logic [7:0] d;
        bus_write(3'd0, 8'd1);
        bus_write(3'd1, 8'd2);
        bus_write(3'd2, 8'd1);
        bus_write(3'd3, 8'h01);
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h01 || res_out !== 16'h0003) begin
            bad++; $display("FAIL edge_status_read got st=%h res=%h want 01 0003", d, res_out);
        end
        bus_write(3'd3, 8'h01);
        bus_write(3'd3, 8'h01);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL edge_start_ignored got busy=%b want 0", busy); end
        bus_read(3'd4, d);
        total++;
        if (d !== 8'h0A) begin bad++; $display("FAIL edge_start_err got %h want 0a", d); end
        bus_write(3'd3, 8'h01);
        bus_write(3'd4, 8'h02);
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL edge_w1c_race got done=%b want 1", done); end
    endtask

    task automatic test_rst_mid_div();
        logic [7:0] d;
        bus_write(3'd0, 8'd200);
        bus_write(3'd1, 8'd7);
        bus_write(3'd2, 8'd4);
        bus_write(3'd3, 8'h01);
        bus_read(3'd0, d);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if ({res_out, busy, done, irq, bus_if.rd_data} !== 27'd0) begin
            bad++;
            $display("FAIL rst_async got res=%h busy=%b done=%b irq=%b rd=%h want all 0",
                     res_out, busy, done, irq, bus_if.rd_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_write(3'd3, 8'h01);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rst_restart got busy=%b want 1", busy); end
        tick();
        total++;
        if (done !== 1'b1 || res_out !== 16'h0000) begin
            bad++; $display("FAIL rst_restart_done got done=%b res=%h want 1 0000", done, res_out);
        end
    endtask

    task automatic test_irq();
        logic [7:0] d;
        bus_write(3'd2, 8'd1);
        bus_write(3'd3, 8'h02);
        bus_read(3'd3, d);
`ifdef ALU_REGFILE_IRQ_EN
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL irq_ctrl_read got %h want 02", d); end
        bus_write(3'd3, 8'h03);
        tick();
        total++;
        if (done !== 1'b1 || irq !== 1'b0) begin
            bad++; $display("FAIL irq_lag got done=%b irq=%b want 1 0", done, irq);
        end
        tick();
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got %b want 1", irq); end
        bus_write(3'd4, 8'h02);
        tick();
        total++;
        if (irq !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL irq_clear got irq=%b done=%b want 0 0", irq, done);
        end
`else
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL irq_ctrl_read got %h want 00", d); end
        bus_write(3'd3, 8'h03);
        tick();
        tick();
        total++;
        if (irq !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL irq_tied got irq=%b done=%b want 0 1", irq, done);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub_mul();
        test_divide();
        test_div0();
        test_hazards();
        test_completion_edge();
        test_rst_mid_div();
        test_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_regfile.md
# alu_regfile

Parametrised memory-mapped ALU: a register file of operand, opcode, control, status and result registers behind a single-port read/write bus. It extends the 4×8 memory/ALU with configurable data width and a 2×DATA_WIDTH result. It adds an explicit start/busy/done handshake, a multi-cycle restoring divider, and sticky error flags. It sits on the same bus-style interface as the existing memory block and is driven by the testbench or a host controller.

## Interface
- DATA_WIDTH, 8: operand/register width; ≥4.
- ADDR_WIDTH, 3: address width; ≥3; locations 7..2^ADDR_WIDTH−1 are unmapped.
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- enable  input  1  bus access strobe, sampled on clk.
- rd_wr  input  1  1 = read, 0 = write.
- addr  input  ADDR_WIDTH  register address.
- wr_data  input  DATA_WIDTH  write data.
- rd_data  output  DATA_WIDTH  registered read data; holds its value when there is no read.
- res_out  output  2*DATA_WIDTH  current result register {RES_HI, RES_LO}.
- busy  output  1  operation in flight.
- done  output  1  sticky completion flag (mirrors STATUS[1]).
- irq  output  1  completion interrupt (see Configuration).

## Operation
- Register map:
  - 0 OPA (rw)
  - 1 OPB (rw)
  - 2 OPER (rw, bits[2:0] used, upper bits read 0)
  - 3 CTRL (bit0 START, write-only, self-clearing, reads 0; bit1 IRQ_EN rw)
  - 4 STATUS (bit0 busy RO, bit1 done W1C, bit2 div0 W1C, bit3 err W1C)
  - 5 RES_LO (RO)
  - 6 RES_HI (RO)
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.
- Writing CTRL with bit0=1 while idle starts an operation:
  - OPA, OPB and OPER are snapshotted.
  - done, div0 and err are cleared, and busy is set.
  - Later writes to OPA/OPB/OPER do not affect the in-flight operation.
- START while busy: ignored, err set, in-flight operation unaffected.
- FSM: IDLE → EXEC (ops other than 4) or DIV (op 4) → IDLE. Result registers, done and flags update on the final edge.
- Ops, all arithmetic on zero-extended operands, modulo 2^(2W):
  - 0: result = 0.
  - 1: A+B, carry lands in bit W.
  - 2: A−B, two's complement, e.g. 5−7 = 0xFFFE for W=8.
  - 3: A*B, full product.
  - 4: RES_LO = quotient, RES_HI = remainder via restoring divider, one quotient bit per cycle.
  - 4 with B=0: RES_LO = all-ones, RES_HI = A, div0 set; still takes the full divide latency.
  - 5–7: result unchanged, err set, done set.
- Reset values: OPA, OPB, OPER, CTRL, STATUS, results, rd_data, busy, done and irq are all 0.

## Timing
- Edge T0 is the edge that samples the START write. busy is 1 from after T0 until the completion edge.
- Ops 0–3 and 5–7 complete at T1: result and done visible after T1, busy low after T1.
- Op 4 completes at T(DATA_WIDTH): busy lasts DATA_WIDTH cycles.
- Reads have 1-cycle latency: rd_data updates on the sampling edge with the pre-edge register value. A STATUS read on the completion edge returns busy=1, done=0.
- A W1C write to done on the same edge that completion sets done: the set wins.
- A START write on the completion edge is treated as busy: it is ignored and err is set.
- Asserting rst mid-division aborts it. All outputs go to 0 asynchronously. After deassertion the block is IDLE and accepts START on the next edge.

## Configuration
- ALU_REGFILE_IRQ_EN defined:
  - CTRL bit1 IRQ_EN is implemented.
  - irq = IRQ_EN & done, registered, and drops when done is cleared.
- ALU_REGFILE_IRQ_EN undefined:
  - irq is tied 0.
  - CTRL bit1 reads 0 and writes to it are ignored.

## Test plan
- Add (W=8): OPA=200, OPB=100, OPER=1, START → one cycle later res_out=0x012C, done=1, busy=0; STATUS read=0x02.
- Sub and mul: 5−7 → 0xFFFE. 255×255 → 0xFE01. Each completes in 1 cycle; err=0.
- Divide: OPA=200, OPB=7, OPER=4, START → busy for exactly 8 cycles, then RES_LO=0x1C, RES_HI=0x04. Overwriting OPA mid-divide does not change the result.
- Divide by zero: OPA=0x55, OPB=0, OPER=4 → after 8 cycles RES_LO=0xFF, RES_HI=0x55, STATUS=0x06. Writing 0x04 to STATUS clears div0 only.
- Hazards: START during a divide → err=1 and the original divide completes correctly. OPER=6 → err=1, done=1, result unchanged. Asserting rst mid-divide → all outputs 0 without waiting for a clock edge.
- IRQ (macro defined): IRQ_EN=1, add → irq=1 the cycle after done. W1C of done → irq=0. With the macro undefined, irq stays 0 and CTRL reads 0x00.
